alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Operand issue stage directly upstream of the ALU function units (bitwise OR, AND, XOR, adder, shifter). It accepts operation requests over a valid/ready handshake and buffers them in a 2-entry queue. It presents the head entry's operands to the units, together with a one-hot unit-enable vector. The units' `enable` gating zeroes their operands whenever their enable bit is low, so only the selected unit sees live data.

## Interface
- `WIDTH`, 32, operand width
- `CNT_WIDTH`, 16, width of the issued-operation counter
- `clk`  input  1  single clock, rising edge
- `rst`  input  1  asynchronous, active-high reset
- `flush`  input  1  synchronous queue clear
- `in_valid`  input  1  request valid
- `in_ready`  output  1  stage can accept a request this cycle
- `in_opcode`  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA
- `in_op1`  input  WIDTH  operand 1
- `in_op2`  input  WIDTH  operand 2
- `out_valid`  output  1  head entry valid
- `out_ready`  input  1  downstream consumes head this cycle
- `out_op1`  output  WIDTH  head operand 1; 0 when empty
- `out_op2`  output  WIDTH  head operand 2; 0 when empty
- `out_en`  output  8  one-hot enable, bit = head opcode; all-zero when empty
- `issued_cnt`  output  CNT_WIDTH  count of completed output handshakes

## Operation
- Storage: two entries of {opcode, op1, op2}, a 1-bit write pointer, a 1-bit read pointer and a 2-bit occupancy `count` (0..2).
- Push: `in_valid && in_ready`. Writes the entry at the write pointer and toggles the write pointer.
- Pop: `out_valid && out_ready`. Toggles the read pointer and increments `issued_cnt`.
- `in_ready = (count != 2)`. It depends only on registered state. When count is 2, a same-cycle pop does not open a push slot.
- `out_valid = (count != 0)`.
- `out_op1`, `out_op2` and `out_en` are driven from the head entry when valid and are forced to 0 when empty.
- Occupancy update:
  - push only: +1
  - pop only: −1
  - push and pop together (count 1): unchanged, and the head advances to the newly written entry
  - push and pop together (count 0): impossible, because a push at count 0 is not visible until the next cycle
- Flush:
  - Sets count, write pointer and read pointer to 0.
  - Overrides a push or pop in the same cycle. The flushed pop is not counted.
  - `issued_cnt` is not cleared by flush.
- `issued_cnt` wraps from 2^CNT_WIDTH−1 to 0.
- Opcode decode to `out_en` is a pure function of the stored head opcode. All 8 codes are legal.
- Entry contents are not reset. Only control state is reset.

## Timing
- Reset (asynchronous assert, synchronous release by the integrator):
  - count = 0, pointers = 0, issued_cnt = 0
  - outputs: in_ready = 1, out_valid = 0, out_op1 = 0, out_op2 = 0, out_en = 0
- Latency: a request accepted at edge N appears on the outputs after edge N, i.e. it is visible in cycle N+1.
- Throughput: 1 op/cycle while `out_ready` is held high.
- Ordering: strict FIFO.
- Output stability: while `out_valid && !out_ready`, `out_op1`, `out_op2` and `out_en` hold stable.
- Reset asserted mid-operation: all buffered entries are discarded immediately, with no handshake completing in that cycle.

## Test plan
- Reset, then idle:
  - in_ready = 1, out_valid = 0, out_en = 8'h00, issued_cnt = 0.
- Single OR op:
  - Stimulus: push opcode 3, op1 = 32'hF0F0_0000, op2 = 32'h0000_0F0F, with out_ready = 1.
  - Response: in the next cycle out_valid = 1, out_en = 8'h08, operands unchanged; in the cycle after, out_valid = 0 and issued_cnt = 1.
- Backpressure fill:
  - Stimulus: out_ready = 0; push ADD (1, 2), then XOR (3, 4), then attempt SUB (5, 6).
  - Response: in_ready = 0 after the second push, and the third push is not accepted.
  - Then release out_ready: the bench sees out_en 8'h01 then 8'h10 with operands (1, 2), (3, 4); issued_cnt = 2.
- Streaming:
  - Stimulus: 100 back-to-back pushes of random opcodes and operands, out_ready = 1.
  - Response: 100 outputs in order, each with out_en = 1 << opcode, none lost; issued_cnt = 100.
- Flush:
  - Stimulus: with 2 entries held, assert flush together with out_ready = 1 and in_valid = 1.
  - Response: next cycle count = 0, out_valid = 0, issued_cnt unchanged, and the pushed op is discarded.
- Async reset mid-stream and counter wrap:
  - Assert rst between clock edges with 1 entry held: out_valid = 0 immediately and issued_cnt = 0.
  - With CNT_WIDTH = 4, complete 17 pops: issued_cnt = 1.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - request/issue handshake bundle for the ALU issue stage
interface alu_issue_stage_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_opcode;
    logic [WIDTH-1:0] in_op1;
    logic [WIDTH-1:0] in_op2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_op1;
    logic [WIDTH-1:0] out_op2;
    logic [7:0]       out_en;

    modport master (
        output in_valid, in_opcode, in_op1, in_op2, out_ready,
        input  in_ready, out_valid, out_op1, out_op2, out_en
    );

    modport slave (
        input  in_valid, in_opcode, in_op1, in_op2, out_ready,
        output in_ready, out_valid, out_op1, out_op2, out_en
    );
endinterface

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - 2-entry operand queue feeding the ALU units with a one-hot unit enable
module alu_issue_stage #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    alu_issue_stage_if.slave     bus,
    output logic [CNT_WIDTH-1:0] issued_cnt
);
    logic [1:0]           count_q, count_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [2:0]       opc_q [2];
    logic [2:0]       opc_d [2];
    logic [WIDTH-1:0] op1_q [2];
    logic [WIDTH-1:0] op1_d [2];
    logic [WIDTH-1:0] op2_q [2];
    logic [WIDTH-1:0] op2_d [2];

    logic in_ready_s;
    logic out_valid_s;
    logic push;
    logic pop;

    // ready looks only at registered occupancy, so a full queue never accepts even when popping
    assign in_ready_s  = (count_q != 2'd2);
    assign out_valid_s = (count_q != 2'd0);
    assign push        = bus.in_valid && in_ready_s;
    assign pop         = out_valid_s && bus.out_ready;

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_op1   = out_valid_s ? op1_q[rd_ptr_q] : '0;
    assign bus.out_op2   = out_valid_s ? op2_q[rd_ptr_q] : '0;
    assign bus.out_en    = out_valid_s ? (8'd1 << opc_q[rd_ptr_q]) : 8'd0;
    assign issued_cnt    = cnt_q;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + {{(CNT_WIDTH-1){1'b0}}, pop};
        opc_d    = opc_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        if (flush) begin
            // a pop in the flush cycle is discarded, so it does not count as issued
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            cnt_d    = cnt_q;
        end else begin
            count_d = count_q + {1'b0, push} - {1'b0, pop};
            if (push) begin
                wr_ptr_d        = ~wr_ptr_q;
                opc_d[wr_ptr_q] = bus.in_opcode;
                op1_d[wr_ptr_q] = bus.in_op1;
                op2_d[wr_ptr_q] = bus.in_op2;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // payload storage carries no reset; validity is tracked by count_q alone
    always_ff @(posedge clk) begin
        opc_q <= opc_d;
        op1_q <= op1_d;
        op2_q <= op2_d;
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - randomized self-checking bench for alu_issue_stage
module tb_alu_issue_stage;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic wrap_flush = 1'b0;
    logic [15:0] issued_cnt;
    logic [3:0]  wrap_cnt;

    always #5 clk = ~clk;

    alu_issue_stage_if #(.WIDTH(W)) bus ();
    alu_issue_stage_if #(.WIDTH(W)) bus_w ();

    alu_issue_stage #(.WIDTH(W), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus), .issued_cnt(issued_cnt)
    );

    alu_issue_stage #(.WIDTH(W), .CNT_WIDTH(4)) u_wrap (
        .clk(clk), .rst(rst), .flush(wrap_flush), .bus(bus_w), .issued_cnt(wrap_cnt)
    );

    typedef struct {
        logic [2:0]   opc;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } op_t;

    op_t mq[$];
    int  exp_cnt = 0;
    int  checks = 0;
    int  failures = 0;

    function automatic logic m_valid();
        return mq.size() != 0;
    endfunction

    function automatic logic [7:0] m_en();
        logic [7:0] r;
        r = 8'h00;
        if (mq.size() != 0) r[mq[0].opc] = 1'b1;
        return r;
    endfunction

    function automatic logic [W-1:0] m_op1();
        return (mq.size() != 0) ? mq[0].a : '0;
    endfunction

    function automatic logic [W-1:0] m_op2();
        return (mq.size() != 0) ? mq[0].b : '0;
    endfunction

    // One clock: drive inputs (called just after a falling edge), apply the queue model at the rising edge.
    task automatic step(input logic v, input logic [2:0] opc, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ordy, input logic fl);
        bit  push_m, pop_m;
        op_t e;
        bus.in_valid  = v;
        bus.in_opcode = opc;
        bus.in_op1    = a;
        bus.in_op2    = b;
        bus.out_ready = ordy;
        flush         = fl;
        push_m = v && (mq.size() < 2);
        pop_m  = ordy && (mq.size() != 0);
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (pop_m) begin
                void'(mq.pop_front());
                exp_cnt = (exp_cnt + 1) % 65536;
            end
            if (push_m) begin
                e.opc = opc; e.a = a; e.b = b;
                mq.push_back(e);
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 0; bus.in_opcode = 0; bus.in_op1 = 0; bus.in_op2 = 0; bus.out_ready = 0;
        bus_w.in_valid = 0; bus_w.in_opcode = 0; bus_w.in_op1 = 0; bus_w.in_op2 = 0; bus_w.out_ready = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_en !== 8'h00) begin failures++; $display("FAIL reset_out_en got=%h exp=00", bus.out_en); end
        checks++; if (bus.out_op1 !== 32'h0 || bus.out_op2 !== 32'h0) begin failures++; $display("FAIL reset_ops got=%h/%h exp=0/0", bus.out_op1, bus.out_op2); end
        checks++; if (issued_cnt !== 16'd0) begin failures++; $display("FAIL reset_issued got=%0d exp=0", issued_cnt); end
    endtask

    task automatic test_single_or();
        step(1'b1, 3'd3, 32'hF0F0_0000, 32'h0000_0F0F, 1'b1, 1'b0);
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL or_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_en !== 8'h08) begin failures++; $display("FAIL or_en got=%h exp=08", bus.out_en); end
        checks++; if (bus.out_op1 !== 32'hF0F0_0000 || bus.out_op2 !== 32'h0000_0F0F) begin
            failures++; $display("FAIL or_ops got=%h/%h exp=f0f00000/00000f0f", bus.out_op1, bus.out_op2); end
        step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL or_drain_valid got=%b exp=0", bus.out_valid); end
        checks++; if (issued_cnt !== 16'd1) begin failures++; $display("FAIL or_issued got=%0d exp=1", issued_cnt); end
    endtask

    task automatic test_backpressure();
        int base;
        base = exp_cnt;
        step(1'b1, 3'd0, 32'd1, 32'd2, 1'b0, 1'b0);
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%b exp=1", bus.in_ready); end
        step(1'b1, 3'd4, 32'd3, 32'd4, 1'b0, 1'b0);
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready2 got=%b exp=0", bus.in_ready); end
        step(1'b1, 3'd1, 32'd5, 32'd6, 1'b0, 1'b0);
        checks++; if (bus.out_en !== 8'h01 || bus.out_op1 !== 32'd1 || bus.out_op2 !== 32'd2) begin
            failures++; $display("FAIL bp_head1 got=%h %0d %0d exp=01 1 2", bus.out_en, bus.out_op1, bus.out_op2); end
        step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++; if (bus.out_en !== 8'h10 || bus.out_op1 !== 32'd3 || bus.out_op2 !== 32'd4) begin
            failures++; $display("FAIL bp_head2 got=%h %0d %0d exp=10 3 4", bus.out_en, bus.out_op1, bus.out_op2); end
        step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_sub_dropped got=%b exp=0", bus.out_valid); end
        checks++; if (issued_cnt !== 16'(base + 2)) begin failures++; $display("FAIL bp_issued got=%0d exp=%0d", issued_cnt, base + 2); end
    endtask

    task automatic test_streaming();
        int base;
        int bad;
        base = exp_cnt;
        bad  = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom, 1'b1, 1'b0);
            checks++;
            if (bus.out_valid !== m_valid() || bus.out_en !== m_en() || bus.out_op1 !== m_op1() || bus.out_op2 !== m_op2()
                || bus.in_ready !== 1'b1) begin
                failures++; bad++;
                if (bad < 5) $display("FAIL stream_%0d got=%b %h %h %h exp=%b %h %h %h", i,
                    bus.out_valid, bus.out_en, bus.out_op1, bus.out_op2, m_valid(), m_en(), m_op1(), m_op2());
            end
        end
        step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++; if (issued_cnt !== 16'(base + 100)) begin failures++; $display("FAIL stream_issued got=%0d exp=%0d", issued_cnt, base + 100); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_flush();
        int base;
        step(1'b1, 3'd5, 32'hAAAA_0001, 32'd7, 1'b0, 1'b0);
        step(1'b1, 3'd6, 32'hBBBB_0002, 32'd9, 1'b0, 1'b0);
        base = exp_cnt;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL flush_full got=%b exp=0", bus.in_ready); end
        step(1'b1, 3'd7, 32'hCCCC_0003, 32'd1, 1'b1, 1'b1);
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_en !== 8'h00) begin
            failures++; $display("FAIL flush_empty got=%b %b %h exp=0 1 00", bus.out_valid, bus.in_ready, bus.out_en); end
        checks++; if (issued_cnt !== 16'(base)) begin failures++; $display("FAIL flush_issued got=%0d exp=%0d", issued_cnt, base); end
        step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++; if (bus.out_valid !== 1'b0 || issued_cnt !== 16'(base)) begin
            failures++; $display("FAIL flush_discard got=%b %0d exp=0 %0d", bus.out_valid, issued_cnt, base); end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom), 3'($urandom), $urandom, $urandom, 1'($urandom), ($urandom_range(0, 15) == 0));
            checks++;
            if (bus.in_ready !== (mq.size() < 2) || bus.out_valid !== m_valid() || bus.out_en !== m_en()
                || bus.out_op1 !== m_op1() || bus.out_op2 !== m_op2() || issued_cnt !== 16'(exp_cnt)) begin
                failures++; bad++;
                if (bad < 5) $display("FAIL random_%0d got=%b %b %h %h cnt=%0d exp=%b %b %h %h cnt=%0d", i,
                    bus.in_ready, bus.out_valid, bus.out_en, bus.out_op1, issued_cnt,
                    (mq.size() < 2), m_valid(), m_en(), m_op1(), exp_cnt);
            end
        end
    endtask

    task automatic test_async_reset();
        step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 3'd2, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_en !== 8'h04) begin
            failures++; $display("FAIL areset_pre got=%b %h exp=1 04", bus.out_valid, bus.out_en); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_en !== 8'h00 || bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL areset_now got=%b %h %b exp=0 00 1", bus.out_valid, bus.out_en, bus.in_ready); end
        checks++; if (issued_cnt !== 16'd0) begin failures++; $display("FAIL areset_issued got=%0d exp=0", issued_cnt); end
        mq.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++; if (bus.out_valid !== 1'b0 || issued_cnt !== 16'd0) begin
            failures++; $display("FAIL areset_after got=%b %0d exp=0 0", bus.out_valid, issued_cnt); end
    endtask

    task automatic test_counter_wrap();
        checks++; if (wrap_cnt !== 4'd0) begin failures++; $display("FAIL wrap_start got=%0d exp=0", wrap_cnt); end
        for (int i = 0; i < 18; i++) begin
            bus_w.in_valid  = (i < 17);
            bus_w.in_opcode = 3'($urandom);
            bus_w.in_op1    = $urandom;
            bus_w.in_op2    = $urandom;
            bus_w.out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (i == 16) begin
                checks++; if (wrap_cnt !== 4'd0) begin failures++; $display("FAIL wrap_16 got=%0d exp=0", wrap_cnt); end
            end
        end
        bus_w.in_valid = 1'b0;
        checks++; if (wrap_cnt !== 4'd1) begin failures++; $display("FAIL wrap_17 got=%0d exp=1", wrap_cnt); end
        checks++; if (bus_w.out_valid !== 1'b0) begin failures++; $display("FAIL wrap_drain got=%b exp=0", bus_w.out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_or();
        test_backpressure();
        test_streaming();
        test_flush();
        test_random();
        test_async_reset();
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
